// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch slice: widths, reset address and
// response classification used by fetch_unit.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_FILL,
    RSP_DROP,
    RSP_STRAY
  } rsp_kind_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_buf.sv
// In-order reservation FIFO: entries are reserved at request time, filled in
// order by responses and popped by decode. Entries between head and fill are filled.
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             reserve,
  input  logic [XLEN-1:0]  reserve_pc,
  input  logic             fill,
  input  logic [ILEN-1:0]  fill_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [XLEN-1:0]  head_pc,
  output logic [ILEN-1:0]  head_data,
  output logic [CNT_W-1:0] reserved_cnt,
  output logic [CNT_W-1:0] pending_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CNT_W-1:0] head_ptr;
  logic [CNT_W-1:0] tail_ptr;
  logic [CNT_W-1:0] fill_ptr;
  logic [XLEN-1:0]  pc_mem   [DEPTH];
  logic [ILEN-1:0]  data_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (flush) begin
      head_ptr <= tail_ptr;
      fill_ptr <= tail_ptr;
    end else begin
      if (reserve) begin
        pc_mem[tail_ptr[PTR_W-1:0]] <= reserve_pc;
        tail_ptr <= tail_ptr + CNT_W'(1);
      end
      if (fill) begin
        data_mem[fill_ptr[PTR_W-1:0]] <= fill_data;
        fill_ptr <= fill_ptr + CNT_W'(1);
      end
      if (pop) begin
        head_ptr <= head_ptr + CNT_W'(1);
      end
    end
  end

  always_comb begin
    reserved_cnt = tail_ptr - head_ptr;
    pending_cnt  = tail_ptr - fill_ptr;
    head_valid   = (fill_ptr != head_ptr);
    head_pc      = pc_mem[head_ptr[PTR_W-1:0]];
    head_data    = data_mem[head_ptr[PTR_W-1:0]];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: sequential PC generation, imem request/response
// handshake, redirect with drop counting of stale in-flight responses.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] drop_cnt_next;
  logic [CNT_W-1:0] reserved_cnt;
  logic [CNT_W-1:0] pending_cnt;
  logic [CNT_W:0]   occupancy;
  logic             head_valid;
  logic [XLEN-1:0]  head_pc;
  logic [ILEN-1:0]  head_data;
  logic             issue;
  logic             fill;
  logic             pop;
  rsp_kind_e        rsp_kind;

  // Slots owed to stale responses count against capacity just like reservations.
  always_comb begin
    occupancy      = {1'b0, reserved_cnt} + {1'b0, drop_cnt};
    imem_req_valid = rst && !redirect_valid && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    imem_req_addr  = fetch_pc;
    issue          = imem_req_valid && imem_req_ready;
    pop            = rst && !redirect_valid && head_valid && instr_ready;
    instr_valid    = rst && head_valid;
    instr_data     = rst ? head_data : '0;
    instr_pc       = rst ? head_pc : '0;
  end

  always_comb begin
    rsp_kind = RSP_NONE;
    if (imem_rsp_valid) begin
      if (drop_cnt != '0) begin
        rsp_kind = RSP_DROP;
      end else if (pending_cnt != '0) begin
        rsp_kind = RSP_FILL;
      end else begin
        rsp_kind = RSP_STRAY;
      end
    end
    fill = (rsp_kind == RSP_FILL) && !redirect_valid;
  end

  // A redirect turns every still-unfilled reservation into a response to discard,
  // except one that is being answered in this very cycle.
  always_comb begin
    drop_cnt_next = drop_cnt;
    if (rsp_kind == RSP_DROP) begin
      drop_cnt_next = drop_cnt - CNT_W'(1);
    end
    if (redirect_valid) begin
      drop_cnt_next = drop_cnt_next + pending_cnt
                    - ((rsp_kind == RSP_FILL) ? CNT_W'(1) : CNT_W'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= word_align(RESET_PC);
      drop_cnt <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= word_align(redirect_pc);
      end else if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      drop_cnt <= drop_cnt_next;
    end
  end

  fetch_buf #(
    .DEPTH(FIFO_DEPTH)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .flush        (redirect_valid),
    .reserve      (issue),
    .reserve_pc   (fetch_pc),
    .fill         (fill),
    .fill_data    (imem_rsp_data),
    .pop          (pop),
    .head_valid   (head_valid),
    .head_pc      (head_pc),
    .head_data    (head_data),
    .reserved_cnt (reserved_cnt),
    .pending_cnt  (pending_cnt)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, backpressure, redirect,
// PC wrap and redirect colliding with a response and a pop.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  logic        mem_auto;
  logic        auto_valid = 1'b0;
  logic [31:0] auto_data  = '0;
  logic        man_valid;
  logic [31:0] man_data;
  logic        acc1;
  logic [31:0] acc1_addr;

  logic        req_valid2;
  logic        req_ready2;
  logic [31:0] req_addr2;
  logic        rsp_valid2 = 1'b0;
  logic [31:0] rsp_data2  = '0;
  logic        instr_valid2;
  logic        instr_ready2;
  logic [31:0] instr_data2;
  logic [31:0] instr_pc2;
  logic        redirect_valid2;
  logic [31:0] redirect_pc2;
  logic        acc2;
  logic [31:0] acc2_addr;

  int checks = 0;
  int passed = 0;
  int outstanding = 0;

  always #5 clk = ~clk;

  assign imem_rsp_valid = mem_auto ? auto_valid : man_valid;
  assign imem_rsp_data  = mem_auto ? auto_data  : man_data;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  fetch_unit #(
    .RESET_PC   (32'hFFFF_FFF8),
    .FIFO_DEPTH (2)
  ) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid2),
    .redirect_pc    (redirect_pc2),
    .imem_req_valid (req_valid2),
    .imem_req_ready (req_ready2),
    .imem_req_addr  (req_addr2),
    .imem_rsp_valid (rsp_valid2),
    .imem_rsp_data  (rsp_data2),
    .instr_valid    (instr_valid2),
    .instr_ready    (instr_ready2),
    .instr_data     (instr_data2),
    .instr_pc       (instr_pc2)
  );

  // One-cycle memory models: answer every accepted request in the next cycle.
  initial forever begin
    @(posedge clk);
    acc1      = imem_req_valid && imem_req_ready;
    acc1_addr = imem_req_addr;
    #1;
    auto_valid = acc1;
    auto_data  = acc1_addr ^ 32'hA5A5_0000;
  end

  initial forever begin
    @(posedge clk);
    acc2      = req_valid2 && req_ready2;
    acc2_addr = req_addr2;
    #1;
    rsp_valid2 = acc2;
    rsp_data2  = acc2_addr ^ 32'hA5A5_0000;
  end

  // Protocol watch: a response must always answer an earlier accepted request.
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      outstanding = 0;
    end else begin
      if (imem_rsp_valid) begin
        assert (outstanding > 0) else $error("[TB] response with nothing outstanding");
        if (outstanding > 0) outstanding--;
      end
      if (imem_req_valid && imem_req_ready) outstanding++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst            = 1'b0;
    mem_auto       = 1'b0;
    man_valid      = 1'b0;
    man_data       = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst            = 1'b0;
    mem_auto       = 1'b1;
    man_valid      = 1'b0;
    man_data       = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (imem_req_valid !== 1'b0) $display("[TB] FAIL reset_req_valid cyc%0d: got %b want 0", i, imem_req_valid);
      else passed++;
      checks++;
      if (instr_valid !== 1'b0) $display("[TB] FAIL reset_instr_valid cyc%0d: got %b want 0", i, instr_valid);
      else passed++;
      checks++;
      if (instr_pc !== 32'h0 || instr_data !== 32'h0)
        $display("[TB] FAIL reset_outputs cyc%0d: got pc=%h data=%h want 0/0", i, instr_pc, instr_data);
      else passed++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1) $display("[TB] FAIL first_req_valid: got %b want 1", imem_req_valid);
    else passed++;
    checks++;
    if (imem_req_addr !== 32'h0) $display("[TB] FAIL first_req_addr: got %h want 00000000", imem_req_addr);
    else passed++;
    checks++;
    if (instr_valid !== 1'b0) $display("[TB] FAIL first_instr_valid: got %b want 0", instr_valid);
    else passed++;
  endtask

  task automatic test_stream();
    int          got;
    logic [31:0] exp_pc;
    reset_dut();
    mem_auto       = 1'b1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    #1;
    tick();
    checks++;
    if (instr_valid !== 1'b0) $display("[TB] FAIL stream_fill_latency: got %b want 0", instr_valid);
    else passed++;
    tick();
    checks++;
    if (instr_valid !== 1'b1) $display("[TB] FAIL stream_first_valid: got %b want 1", instr_valid);
    else passed++;
    got    = 0;
    exp_pc = 32'h0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (instr_valid) begin
        checks++;
        if (instr_pc !== exp_pc) $display("[TB] FAIL stream_pc #%0d: got %h want %h", got, instr_pc, exp_pc);
        else passed++;
        checks++;
        if (instr_data !== (exp_pc ^ 32'hA5A5_0000))
          $display("[TB] FAIL stream_data #%0d: got %h want %h", got, instr_data, exp_pc ^ 32'hA5A5_0000);
        else passed++;
        got++;
        exp_pc = exp_pc + 32'd4;
      end
      tick();
    end
    checks++;
    if (got != 6) $display("[TB] FAIL stream_count: got %0d want 6", got);
    else passed++;
  endtask

  task automatic test_backpressure();
    int          accepts;
    int          got;
    logic [31:0] exp_pc;
    reset_dut();
    mem_auto       = 1'b1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    #1;
    accepts = 0;
    for (int c = 0; c < 6; c++) begin
      if (imem_req_valid && imem_req_ready) accepts++;
      tick();
    end
    checks++;
    if (accepts != 2) $display("[TB] FAIL bp_accepts: got %0d want 2", accepts);
    else passed++;
    checks++;
    if (imem_req_valid !== 1'b0) $display("[TB] FAIL bp_req_stalled: got %b want 0", imem_req_valid);
    else passed++;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0)
      $display("[TB] FAIL bp_head_held: got valid=%b pc=%h want 1/00000000", instr_valid, instr_pc);
    else passed++;
    instr_ready = 1'b1;
    #1;
    got    = 0;
    exp_pc = 32'h0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (instr_valid) begin
        checks++;
        if (instr_pc !== exp_pc || instr_data !== (exp_pc ^ 32'hA5A5_0000))
          $display("[TB] FAIL bp_drain #%0d: got pc=%h data=%h want pc=%h data=%h",
                   got, instr_pc, instr_data, exp_pc, exp_pc ^ 32'hA5A5_0000);
        else passed++;
        got++;
        exp_pc = exp_pc + 32'd4;
      end
      tick();
    end
    checks++;
    if (got != 5) $display("[TB] FAIL bp_drain_count: got %0d want 5", got);
    else passed++;
  endtask

  task automatic test_redirect();
    reset_dut();
    mem_auto       = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    #1;
    tick();
    tick();
    checks++;
    if (imem_req_valid !== 1'b0) $display("[TB] FAIL redir_full: got %b want 0", imem_req_valid);
    else passed++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) $display("[TB] FAIL redir_issue_suppressed: got %b want 0", imem_req_valid);
    else passed++;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req_addr !== 32'h0000_0100) $display("[TB] FAIL redir_addr: got %h want 00000100", imem_req_addr);
    else passed++;
    checks++;
    if (imem_req_valid !== 1'b0) $display("[TB] FAIL redir_drop_block: got %b want 0", imem_req_valid);
    else passed++;
    man_valid = 1'b1;
    man_data  = 32'hDEAD_0000;
    tick();
    man_data = 32'hBEEF_0004;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0100)
      $display("[TB] FAIL redir_first_req: got valid=%b addr=%h want 1/00000100", imem_req_valid, imem_req_addr);
    else passed++;
    checks++;
    if (instr_valid !== 1'b0) $display("[TB] FAIL redir_stale1: got %b want 0", instr_valid);
    else passed++;
    tick();
    man_valid = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0) $display("[TB] FAIL redir_stale2: got %b want 0", instr_valid);
    else passed++;
    checks++;
    if (imem_req_addr !== 32'h0000_0104) $display("[TB] FAIL redir_next_addr: got %h want 00000104", imem_req_addr);
    else passed++;
    man_valid = 1'b1;
    man_data  = 32'h1234_0100;
    tick();
    man_valid      = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_0100 || instr_data !== 32'h1234_0100)
      $display("[TB] FAIL redir_first_instr: got valid=%b pc=%h data=%h want 1/00000100/12340100",
               instr_valid, instr_pc, instr_data);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [4];
    int          n;
    exp_addr[0] = 32'hFFFF_FFF8;
    exp_addr[1] = 32'hFFFF_FFFC;
    exp_addr[2] = 32'h0000_0000;
    exp_addr[3] = 32'h0000_0004;
    reset_dut();
    #1;
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      if (req_valid2) begin
        checks++;
        if (req_addr2 !== exp_addr[n]) $display("[TB] FAIL wrap_addr #%0d: got %h want %h", n, req_addr2, exp_addr[n]);
        else passed++;
        n++;
      end
      tick();
    end
    checks++;
    if (n != 4) $display("[TB] FAIL wrap_count: got %0d want 4", n);
    else passed++;
  endtask

  task automatic test_redirect_collision();
    reset_dut();
    mem_auto       = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    #1;
    tick();
    man_valid = 1'b1;
    man_data  = 32'h0000_AAAA;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0)
      $display("[TB] FAIL coll_setup: got valid=%b pc=%h want 1/00000000", instr_valid, instr_pc);
    else passed++;
    man_data       = 32'h0000_BBBB;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    man_valid      = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0) $display("[TB] FAIL coll_flushed: got %b want 0", instr_valid);
    else passed++;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0200)
      $display("[TB] FAIL coll_req: got valid=%b addr=%h want 1/00000200", imem_req_valid, imem_req_addr);
    else passed++;
    tick();
    checks++;
    if (instr_valid !== 1'b0) $display("[TB] FAIL coll_no_spurious: got %b want 0", instr_valid);
    else passed++;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0204)
      $display("[TB] FAIL coll_drop_zero: got valid=%b addr=%h want 1/00000204", imem_req_valid, imem_req_addr);
    else passed++;
    man_valid      = 1'b1;
    man_data       = 32'h0000_CCCC;
    imem_req_ready = 1'b0;
    tick();
    man_valid = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_0200 || instr_data !== 32'h0000_CCCC)
      $display("[TB] FAIL coll_new_instr: got valid=%b pc=%h data=%h want 1/00000200/0000cccc",
               instr_valid, instr_pc, instr_data);
    else passed++;
  endtask

  initial begin
    rst             = 1'b0;
    redirect_valid2 = 1'b0;
    redirect_pc2    = '0;
    req_ready2      = 1'b1;
    instr_ready2    = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_redirect_collision();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
